sequential_divider: RTL and testbench
=====================================

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division, sampled on the rising edge of clk.
REQ-005 SHALL have port A, input, WIDTH bits: dividend, two's-complement signed, captured when start is accepted.
REQ-006 SHALL have port B, input, WIDTH bits: divisor, two's-complement signed, captured when start is accepted.
REQ-007 SHALL have port Quotient, output, WIDTH bits: signed quotient, registered.
REQ-008 SHALL have port Remainder, output, WIDTH bits: signed remainder, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse that marks Quotient and Remainder as valid.
REQ-011 SHALL have port div_by_zero, output, 1 bit: divide-by-zero flag, registered.

Function
REQ-012 SHALL implement states IDLE, RUN and FIX with transitions IDLE->RUN on start, RUN->FIX after 32 iterations, and FIX->IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE and ignore start in RUN and FIX, so that captured operands and progress are unaffected.
REQ-014 SHALL, on acceptance, capture the magnitudes |A| and |B| (negation is ~x+1), the sign of A, and the XOR of the sign bits of A and B.
REQ-015 SHALL, in RUN, perform one restoring-division step per cycle: shift the partial remainder left, shift in the next dividend MSB, subtract |B| if the partial remainder is >= |B| and set the quotient bit to 1, otherwise set the quotient bit to 0; a 6-bit counter SHALL count 0..31.
REQ-016 SHALL, in FIX, negate the quotient if the sign XOR is 1, give the remainder the sign of A, load Quotient and Remainder, and assert done for exactly that cycle.
REQ-017 SHALL meet this latency: start accepted at edge N -> busy high from edge N through edge N+32, done high for the cycle following edge N+33 and results updated at that edge; a new start SHALL be accepted at edge N+34 at the earliest.
REQ-018 SHALL hold Quotient, Remainder and div_by_zero stable between done pulses.
REQ-019 SHALL return Quotient=0x80000000 and Remainder=0 for A=0x80000000, B=0xFFFFFFFF (overflow wraps, no flag).
REQ-020 SHALL satisfy A = Quotient*B + Remainder with |Remainder| < |B| for all B != 0.

Reset
REQ-021 SHALL, on rst assertion at any time including mid-RUN, immediately force IDLE, counter=0, Quotient=0, Remainder=0, busy=0, done=0 and div_by_zero=0, discarding any operation in progress.
REQ-022 SHALL accept a start on the first rising edge of clk after rst deasserts.

Configuration
REQ-023 SHALL recognise the macro DIV_ZERO_DETECT_EN; when it is defined and B=0 at acceptance, the state SHALL go IDLE->FIX directly, with done one cycle after acceptance, Quotient=0xFFFFFFFF, Remainder=A and div_by_zero=1.
REQ-024 SHALL, when DIV_ZERO_DETECT_EN is undefined, tie div_by_zero to 0 and run B=0 through the full 32-step algorithm, giving Quotient=0xFFFFFFFF for A>=0, Quotient=0x00000001 for A<0, and Remainder=A.

Verification
REQ-025 SHALL cover: A=100, B=7, start pulse -> done 33 edges later with Quotient=14 and Remainder=2, and busy high for exactly 33 cycles.
REQ-026 SHALL cover: A=-100 (0xFFFFFF9C), B=7 -> Quotient=0xFFFFFFF2 (-14) and Remainder=0xFFFFFFFE (-2); and A=100, B=-7 -> Quotient=-14 and Remainder=2.
REQ-027 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> Quotient=0x80000000, Remainder=0 and div_by_zero=0.
REQ-028 SHALL cover: A=55, B=0 in both builds -> with the macro, done after 1 cycle, Quotient=0xFFFFFFFF, Remainder=55, div_by_zero=1; without it, done after 33 cycles, same Quotient and Remainder, div_by_zero=0.
REQ-029 SHALL cover: start A=1000, B=3, then start A=9, B=2 asserted at iteration 10 -> the second start is ignored and the result is Quotient=333, Remainder=1.
REQ-030 SHALL cover: rst asserted at iteration 15 -> all outputs 0 and no done; then A=9, B=2 started after reset -> Quotient=4 and Remainder=1.

Source files
------------

// File: rtl/sequential_divider.sv
// sequential_divider: signed 32-step restoring divider (IDLE -> RUN -> FIX).
// Ports: clk, rst (async, active high), start, A/B (signed operands, captured
//   when start is accepted in IDLE); Quotient/Remainder/div_by_zero
//   (registered, loaded together with the one-cycle done pulse); busy (not idle).
// Latency: start accepted at edge N -> done high after edge N+33; next start
//   at edge N+34. start is ignored while busy.
// Optional: define DIV_ZERO_DETECT_EN to short-circuit B==0 (IDLE->FIX,
//   Quotient=all ones, Remainder=A, div_by_zero=1). Without it div_by_zero is
//   tied low and B==0 runs through the normal algorithm.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  // Working registers. dvd starts as |A| and fills with quotient bits from
  // the right as dividend bits leave on the left.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] mag_b;
  logic             sign_a;
  logic             sign_q;
  logic [5:0]       cnt;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  // Operand magnitudes. |0x80000000| is 0x80000000 as an unsigned value,
  // which the datapath below handles because it works on unsigned magnitudes.
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             accept;

  assign mag_a_in = A[WIDTH-1] ? negate(A) : A;
  assign mag_b_in = B[WIDTH-1] ? negate(B) : B;
  assign accept   = (state == S_IDLE) && start;

`ifdef DIV_ZERO_DETECT_EN
  logic b_zero;
  assign b_zero = (B == '0);
`endif

  // One restoring step. The shifted remainder needs one extra bit: it can
  // reach 2*|B|-1, and |B| itself may be 2^(WIDTH-1).
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

  assign rem_shift = {rem, dvd[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, mag_b};
  assign q_bit     = (rem_shift >= {1'b0, mag_b});
  assign rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign dvd_step  = {dvd[WIDTH-2:0], q_bit};

  // Sign correction applied on the way out of FIX.
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  assign q_fixed = sign_q ? negate(dvd) : dvd;
  assign r_fixed = sign_a ? negate(rem) : rem;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          state_next = b_zero ? S_FIX : S_RUN;
`else
          state_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (cnt == LAST_STEP) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      rem         <= '0;
      mag_b       <= '0;
      sign_a      <= 1'b0;
      sign_q      <= 1'b0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dvd    <= mag_a_in;
            rem    <= '0;
            mag_b  <= mag_b_in;
            sign_a <= A[WIDTH-1];
            sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
            cnt    <= '0;
`ifdef DIV_ZERO_DETECT_EN
            // Preload the final divide-by-zero answer so FIX emits it
            // unchanged: all-ones quotient (no sign fix), remainder = A.
            if (b_zero) begin
              dvd    <= '1;
              rem    <= mag_a_in;
              sign_q <= 1'b0;
            end
`endif
          end
        end
        S_RUN: begin
          dvd <= dvd_step;
          rem <= rem_step;
          cnt <= (cnt == LAST_STEP) ? 6'd0 : cnt + 6'd1;
        end
        S_FIX: begin
          quotient_q  <= q_fixed;
          remainder_q <= r_fixed;
          done_q      <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_pend;
  logic dz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_pend <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (accept) begin
        dz_pend <= b_zero;
      end
      if (state == S_FIX) begin
        dz_q <= dz_pend;
      end
    end
  end

  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign done      = done_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sequential_divider.sv
// Bench for sequential_divider: vector table driven through a scoreboard
// queue, plus hand sequences for ignored start, mid-run reset and hold.
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  sequential_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dz, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  // Start a division at the next edge, optionally re-pulse start with other
  // operands 'inject_at' edges after acceptance, then wait for done and
  // compare against the scoreboard head.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int exp_lat, input int inject_at);
    int   cyc;
    int   bcnt;
    bit   seen;
    exp_t got;
    sb.push_back(e);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (cyc == inject_at) begin
        A = 32'd9; B = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check({name, "_q"}, Quotient, got.q);
      check({name, "_r"}, Remainder, got.r);
      check({name, "_dz"}, {31'd0, div_by_zero}, {31'd0, got.dz});
      check({name, "_lat"}, cyc, exp_lat);
      check({name, "_busy"}, bcnt, exp_lat);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] hq;
    logic [31:0] hr;
    int dcnt;

    vt.push_back(mk(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33));
    vt.push_back(mk(32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33));
    vt.push_back(mk(32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33));
    vt.push_back(mk(32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33));
    vt.push_back(mk(32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 33));
    vt.push_back(mk(32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33));
    vt.push_back(mk(32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 33));
    vt.push_back(mk(32'd5,          32'h80000000,   32'd0,          32'd5,          1'b0, 33));
    vt.push_back(mk(32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0, 33));
    vt.push_back(mk(32'h80000000,   32'd7,          32'hEDB6DB6E,   32'hFFFFFFFE,   1'b0, 33));
`ifdef DIV_ZERO_DETECT_EN
    vt.push_back(mk(32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,         1'b1, 1));
    vt.push_back(mk(32'hFFFFFFC9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFC9,   1'b1, 1));
`else
    vt.push_back(mk(32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,         1'b0, 33));
    vt.push_back(mk(32'hFFFFFFC9,   32'd0,          32'd1,          32'hFFFFFFC9,   1'b0, 33));
`endif

    // Reset state.
    #12;
    check("rst_q", Quotient, 32'd0);
    check("rst_r", Remainder, 32'd0);
    check("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      e.q = vt[i].q; e.r = vt[i].r; e.dz = vt[i].dz;
      run_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, e, vt[i].lat, -1);
    end

    // Results hold between done pulses and done is a single-cycle pulse.
    hq = Quotient; hr = Remainder;
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("hold_q", Quotient, hq);
    check("hold_r", Remainder, hr);
    check("done_pulse", dcnt, 0);

    // Second start during RUN is ignored.
    e.q = 32'd333; e.r = 32'd1; e.dz = 1'b0;
    run_div("ignore", 32'd1000, 32'd3, e, 33, 10);

    // Reset at iteration 15 discards the operation.
    @(negedge clk);
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_q", Quotient, 32'd0);
    check("midrst_r", Remainder, 32'd0);
    check("midrst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (36) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("midrst_nodone", dcnt, 0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    // Start on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    e.q = 32'd4; e.r = 32'd1; e.dz = 1'b0;
    run_div("after_rst", 32'd9, 32'd2, e, 33, -1);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
